// File: rtl/enable_conditioner.sv
// enable_conditioner
//
// Conditions an asynchronous, possibly bouncing raw enable. The raw input is
// synchronized by two flops, then debounced by a four-state FSM. Outputs are a
// clean registered enable level and single-cycle rise/fall strobes. Rejected
// transitions can optionally be counted for diagnostics.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronized samples needed to accept a change
//                    (legal range 1 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH        width of the debounce counter
//
// Ports:
//   clock         in   single clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable_raw    in   asynchronous raw enable, may glitch
//   enable        out  debounced, registered enable level
//   enable_rise   out  one-cycle strobe on an accepted 0->1 change
//   enable_fall   out  one-cycle strobe on an accepted 1->0 change
//   glitch_count  out  saturating count of rejected transitions
//
// Build option:
//   ENABLE_COND_GLITCH_CNT_EN  when defined, the glitch counter is built;
//                              otherwise glitch_count is tied to zero.

module enable_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable_raw,
    output logic       enable,
    output logic       enable_rise,
    output logic       enable_fall,
    output logic [7:0] glitch_count
);

`ifndef SYNTHESIS
    if ((DEBOUNCE_CYCLES < 1) ||
        (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_WIDTH) - 64'd1))) begin : g_cfg_err
        $error("enable_conditioner: DEBOUNCE_CYCLES=%0d out of range for CNT_WIDTH=%0d",
               DEBOUNCE_CYCLES, CNT_WIDTH);
    end
`endif

    typedef enum logic [1:0] {
        StStableLo,
        StCheckHi,
        StStableHi,
        StCheckLo
    } state_e;

    // Final count value, truncated to the counter width.
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
    // With a single-sample debounce, the stable states switch directly.
    localparam bit SingleSample = (DEBOUNCE_CYCLES == 1);

    logic                 q1_q, q2_q;
    logic                 s;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 enable_q, enable_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    // Two-flop synchronizer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= enable_raw;
            q2_q <= q1_q;
        end
    end

    assign s = q2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enable_d = enable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        unique case (state_q)
            StStableLo: begin
                if (s) begin
                    if (SingleSample) begin
                        state_d  = StStableHi;
                        enable_d = 1'b1;
                        rise_d   = 1'b1;
                    end else begin
                        state_d = StCheckHi;
                        cnt_d   = CntOne;
                    end
                end
            end
            StCheckHi: begin
                if (s) begin
                    if (cnt_q == CntLast) begin
                        state_d  = StStableHi;
                        cnt_d    = '0;
                        enable_d = 1'b1;
                        rise_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end
            end
            StStableHi: begin
                if (!s) begin
                    if (SingleSample) begin
                        state_d  = StStableLo;
                        enable_d = 1'b0;
                        fall_d   = 1'b1;
                    end else begin
                        state_d = StCheckLo;
                        cnt_d   = CntOne;
                    end
                end
            end
            StCheckLo: begin
                if (!s) begin
                    if (cnt_q == CntLast) begin
                        state_d  = StStableLo;
                        cnt_d    = '0;
                        enable_d = 1'b0;
                        fall_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StStableLo;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign enable      = enable_q;
    assign enable_rise = rise_q;
    assign enable_fall = fall_q;

`ifdef ENABLE_COND_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;
    logic       glitch_event;

    // A check state seeing the old level again is an aborted transition.
    assign glitch_event = ((state_q == StCheckHi) && !s) || ((state_q == StCheckLo) && s);

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_event && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`else
    assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_enable_conditioner.sv
// Bench for enable_conditioner: a D=4 and a D=1 instance share one raw input.
// Each is compared every cycle against a run-length debounce model, with
// directed checks for reset release, clean edges, glitches, saturation and
// asynchronous reset.

module tb_enable_conditioner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable_raw;
    logic       en4, rise4, fall4;
    logic [7:0] gc4;
    logic       en1, rise1, fall1;
    logic [7:0] gc1;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ENABLE_COND_GLITCH_CNT_EN
    localparam bit GlitchEn = 1'b1;
`else
    localparam bit GlitchEn = 1'b0;
`endif

    always #5 clock = ~clock;

    enable_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (8)
    ) u_dut4 (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_raw  (enable_raw),
        .enable      (en4),
        .enable_rise (rise4),
        .enable_fall (fall4),
        .glitch_count(gc4)
    );

    enable_conditioner #(
        .DEBOUNCE_CYCLES(1),
        .CNT_WIDTH      (8)
    ) u_dut1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_raw  (enable_raw),
        .enable      (en1),
        .enable_rise (rise1),
        .enable_fall (fall1),
        .glitch_count(gc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
            end
        end
    endtask

    // Reference model: raw is delayed by two sampling edges, then a level change
    // is accepted once D consecutive samples disagree with the current level.
    // A disagreeing run that ends early is one glitch.
    int unsigned dcy [2] = '{4, 1};
    logic        sync0, sync1;
    logic        en_m   [2];
    logic        rise_m [2];
    logic        fall_m [2];
    int          run_m  [2];
    int          glitch_m [2];

    function automatic void model_reset();
        sync0 = 1'b0;
        sync1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en_m[k]     = 1'b0;
            rise_m[k]   = 1'b0;
            fall_m[k]   = 1'b0;
            run_m[k]    = 0;
            glitch_m[k] = 0;
        end
    endfunction

    function automatic void model_edge();
        logic smp;
        smp = sync1;
        for (int k = 0; k < 2; k++) begin
            rise_m[k] = 1'b0;
            fall_m[k] = 1'b0;
            if (smp != en_m[k]) begin
                run_m[k]++;
                if (run_m[k] == int'(dcy[k])) begin
                    en_m[k]   = smp;
                    rise_m[k] = smp;
                    fall_m[k] = !smp;
                    run_m[k]  = 0;
                end
            end else if (run_m[k] > 0) begin
                run_m[k] = 0;
                if (glitch_m[k] < 255) glitch_m[k]++;
            end
        end
        sync1 = sync0;
        sync0 = enable_raw;
    endfunction

    function automatic logic [31:0] exp_pack(input int k);
        logic [7:0] g;
        g = GlitchEn ? 8'(glitch_m[k]) : 8'd0;
        return {21'd0, en_m[k], rise_m[k], fall_m[k], g};
    endfunction

    task automatic compare_all();
        check("model_d4", {21'd0, en4, rise4, fall4, gc4}, exp_pack(0));
        check("model_d1", {21'd0, en1, rise1, fall1, gc1}, exp_pack(1));
    endtask

    // One clock edge: advance the model, then sample outputs 1 time unit later.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            if (reset_n) model_edge();
            else model_reset();
            #1;
            compare_all();
        end
    endtask

    initial begin
        int rise_at;
        int fall_at;

        // Reset held with raw already high.
        reset_n    = 1'b0;
        enable_raw = 1'b1;
        model_reset();
        step(3);
        reset_n = 1'b1;
        // Edge k=1 is R, the first edge after release.
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("rel_en4", 32'(en4), 32'(k >= 6));
            check("rel_rise4", 32'(rise4), 32'(k == 6));
            check("rel_en1", 32'(en1), 32'(k >= 3));
            check("rel_rise1", 32'(rise1), 32'(k == 3));
        end

        // Clean fall.
        enable_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("fall_en4", 32'(en4), 32'(k < 6));
            check("fall_str4", 32'(fall4), 32'(k == 6));
            check("fall_str1", 32'(fall1), 32'(k == 3));
        end

        // Two-cycle glitch: rejected at D=4.
        enable_raw = 1'b1;
        step(2);
        enable_raw = 1'b0;
        step(8);
        check("glitch_once", 32'(gc4), GlitchEn ? 32'd1 : 32'd0);
        check("glitch_en4", 32'(en4), 32'd0);

        // One-cycle pulse: accepted at D=1 with strobes on consecutive edges.
        rise_at    = -1;
        fall_at    = -1;
        enable_raw = 1'b1;
        step(1);
        enable_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (rise1) rise_at = k;
            if (fall1) fall_at = k;
        end
        check("pulse_gap_d1", 32'(fall_at - rise_at), 32'd1);
        check("pulse_seen_d1", 32'(rise_at > 0), 32'd1);

        // Saturation: 300 more two-cycle glitches.
        repeat (300) begin
            enable_raw = 1'b1;
            step(2);
            enable_raw = 1'b0;
            step(2);
        end
        step(4);
        check("sat_d4", 32'(gc4), GlitchEn ? 32'd255 : 32'd0);
        check("sat_en4", 32'(en4), 32'd0);

        // Reset in the middle of a rising check.
        enable_raw = 1'b1;
        step(4);
        check("pre_rst_en1", 32'(en1), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_en1", 32'(en1), 32'd0);
        check("async_gc4", 32'(gc4), 32'd0);
        compare_all();
        step(1);
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("rerel_rise4", 32'(rise4), 32'(k == 6));
        end

        // Random raw activity with variable hold times.
        repeat (150) begin
            enable_raw = 1'($urandom_range(0, 1));
            step(int'($urandom_range(1, 7)));
        end
        enable_raw = 1'b0;
        step(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
